turn_scheduler: RTL and testbench

Sequences play for the tic-tac-toe system: it sits between the keypad scanner and the game kernel. It turns keypad presses into one move request per press over a valid/ready handshake, owns whose turn it is, and enforces a per-turn timeout. It also times the win, draw and error display holds and drives the display's 3-bit phase code.

---
 rtl/turn_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_turn_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_scheduler.sv
// Play sequencer between the keypad scanner and the game kernel: one move per key press,
// turn ownership, per-turn timeout, and timed win/draw/error display holds.
module turn_scheduler #(
    parameter int TICK_DIV   = 2500000,
    parameter int TURN_TICKS = 200,
    parameter int HOLD_TICKS = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kb_ready_n,
    input  logic [3:0] kb_key,
    output logic       mv_valid,
    output logic [3:0] mv_cell,
    output logic       mv_player,
    input  logic       mv_ready,
    input  logic       res_valid,
    input  logic [1:0] res_code,
    output logic       turn,
    output logic [2:0] phase,
    output logic       timeout_pulse,
    output logic       board_clr
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(TURN_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {WAIT_KEY, ISSUE, WAIT_RES, HOLD} state_t;

    state_t          state, state_d;
    logic            rdy_s1, rdy_s2, rdy_prev;
    logic            key_evt;
    logic [3:0]      key_r;
    logic [PW-1:0]   presc;
    logic [TW-1:0]   turn_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            tick, timeout, hold_done;
    logic            hold_clr, hold_clr_d;
    logic            turn_d, mv_valid_d, mv_player_d, timeout_d, board_clr_d;
    logic [3:0]      mv_cell_d;
    logic [2:0]      phase_d;

    // Strobe is idle-high, so the synchronizer resets to 1 to avoid a spurious event.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_s1   <= 1'b1;
            rdy_s2   <= 1'b1;
            rdy_prev <= 1'b1;
            key_evt  <= 1'b0;
            key_r    <= '0;
        end else begin
            rdy_s1   <= kb_ready_n;
            rdy_s2   <= rdy_s1;
            rdy_prev <= rdy_s2;
            key_evt  <= rdy_prev & ~rdy_s2;
            if (rdy_prev & ~rdy_s2)
                key_r <= kb_key;
        end
    end

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset || tick)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    // A registered key event beats a timeout tick landing in the same cycle.
    assign timeout   = (state == WAIT_KEY) && !key_evt && tick && (turn_cnt == TURN_LAST);
    assign hold_done = (state == HOLD) && tick && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (reset || state != WAIT_KEY || key_evt || timeout)
            turn_cnt <= '0;
        else if (tick)
            turn_cnt <= turn_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || state != HOLD || hold_done)
            hold_cnt <= '0;
        else if (tick)
            hold_cnt <= hold_cnt + HW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_KEY;
            turn          <= 1'b0;
            phase         <= 3'd0;
            mv_valid      <= 1'b0;
            mv_cell       <= 4'd0;
            mv_player     <= 1'b0;
            hold_clr      <= 1'b0;
            timeout_pulse <= 1'b0;
            board_clr     <= 1'b1;
        end else begin
            state         <= state_d;
            turn          <= turn_d;
            phase         <= phase_d;
            mv_valid      <= mv_valid_d;
            mv_cell       <= mv_cell_d;
            mv_player     <= mv_player_d;
            hold_clr      <= hold_clr_d;
            timeout_pulse <= timeout_d;
            board_clr     <= board_clr_d;
        end
    end

    always_comb begin
        state_d     = state;
        turn_d      = turn;
        phase_d     = phase;
        mv_valid_d  = mv_valid;
        mv_cell_d   = mv_cell;
        mv_player_d = mv_player;
        hold_clr_d  = hold_clr;
        timeout_d   = 1'b0;
        board_clr_d = 1'b0;
        case (state)
            WAIT_KEY: begin
                if (key_evt) begin
                    if (key_r >= 4'd1 && key_r <= 4'd9) begin
                        mv_valid_d  = 1'b1;
                        mv_cell_d   = key_r - 4'd1;
                        mv_player_d = turn;
                        state_d     = ISSUE;
                    end else begin
                        phase_d    = 3'd4;
                        hold_clr_d = 1'b0;
                        state_d    = HOLD;
                    end
                end else if (timeout) begin
                    turn_d    = ~turn;
                    phase_d   = {2'b00, ~turn};
                    timeout_d = 1'b1;
                end
            end
            ISSUE: begin
                if (mv_ready) begin
                    mv_valid_d = 1'b0;
                    state_d    = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_valid) begin
                    case (res_code)
                        2'd0: begin
                            turn_d  = ~turn;
                            phase_d = {2'b00, ~turn};
                            state_d = WAIT_KEY;
                        end
                        2'd1: begin
                            phase_d    = 3'd2 + {2'b00, turn};
                            hold_clr_d = 1'b1;
                            state_d    = HOLD;
                        end
                        2'd2: begin
                            phase_d    = 3'd5;
                            hold_clr_d = 1'b1;
                            state_d    = HOLD;
                        end
                        default: begin
                            phase_d    = 3'd4;
                            hold_clr_d = 1'b0;
                            state_d    = HOLD;
                        end
                    endcase
                end
            end
            HOLD: begin
                if (hold_done) begin
                    state_d = WAIT_KEY;
                    if (hold_clr) begin
                        board_clr_d = 1'b1;
                        turn_d      = 1'b0;
                        phase_d     = 3'd0;
                    end else begin
                        phase_d = {2'b00, turn};
                    end
                end
            end
            default: state_d = WAIT_KEY;
        endcase
    end
endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: directed key/result scenarios, a per-cycle behavioural model,
// and hand-computed literal expectations.
module tb_turn_scheduler;
    localparam int TD = 4;
    localparam int TT = 3;
    localparam int HT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kb_ready_n = 1'b1;
    logic [3:0] kb_key = 4'd0;
    logic       mv_ready = 1'b0;
    logic       res_valid = 1'b0;
    logic [1:0] res_code = 2'd0;
    logic       mv_valid, mv_player, turn, timeout_pulse, board_clr;
    logic [3:0] mv_cell;
    logic [2:0] phase;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    turn_scheduler #(.TICK_DIV(TD), .TURN_TICKS(TT), .HOLD_TICKS(HT)) dut (
        .clk(clk), .reset(reset),
        .kb_ready_n(kb_ready_n), .kb_key(kb_key),
        .mv_valid(mv_valid), .mv_cell(mv_cell), .mv_player(mv_player), .mv_ready(mv_ready),
        .res_valid(res_valid), .res_code(res_code),
        .turn(turn), .phase(phase), .timeout_pulse(timeout_pulse), .board_clr(board_clr)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for key, 1 offering move, 2 awaiting result, 3 display hold
    bit         live = 0;
    int         cyc, mode, ticks;
    bit         hist [4];
    logic [3:0] key_last;
    bit         hclr, m_tick, m_evt;
    logic [3:0] m_key;
    logic       e_valid, e_player, e_turn, e_tp, e_clr;
    logic [3:0] e_cell;
    logic [2:0] e_phase;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            live = 1; cyc = 0; mode = 0; ticks = 0; hclr = 0;
            for (int i = 0; i < 4; i++) hist[i] = 1;
            key_last = 4'd0;
            e_valid = 0; e_cell = 4'd0; e_player = 0; e_turn = 0;
            e_phase = 3'd0; e_tp = 0; e_clr = 1;
        end else begin
            m_tick = (cyc % TD) == TD - 1;
            cyc++;
            // sample four edges back high, three edges back low => press acted on now
            m_evt = hist[3] && !hist[2];
            m_key = key_last;
            hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = kb_ready_n;
            key_last = kb_key;
            e_tp = 0; e_clr = 0;
            case (mode)
                0: begin
                    if (m_evt) begin
                        if (m_key >= 4'd1 && m_key <= 4'd9) begin
                            e_valid = 1; e_cell = m_key - 4'd1; e_player = e_turn; mode = 1;
                        end else begin
                            e_phase = 3'd4; hclr = 0; mode = 3; ticks = 0;
                        end
                    end else if (m_tick) begin
                        ticks++;
                        if (ticks == TT) begin
                            e_turn = !e_turn; e_phase = {2'b00, e_turn}; e_tp = 1; ticks = 0;
                        end
                    end
                end
                1: if (mv_ready) begin e_valid = 0; mode = 2; end
                2: if (res_valid) begin
                    ticks = 0;
                    case (res_code)
                        2'd0: begin e_turn = !e_turn; e_phase = {2'b00, e_turn}; mode = 0; end
                        2'd1: begin e_phase = 3'd2 + {2'b00, e_turn}; hclr = 1; mode = 3; end
                        2'd2: begin e_phase = 3'd5; hclr = 1; mode = 3; end
                        default: begin e_phase = 3'd4; hclr = 0; mode = 3; end
                    endcase
                end
                default: if (m_tick) begin
                    ticks++;
                    if (ticks == HT) begin
                        mode = 0; ticks = 0;
                        if (hclr) begin e_clr = 1; e_turn = 0; end
                        e_phase = {2'b00, e_turn};
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (live) begin
            vectors++;
            if ({mv_valid, mv_cell, mv_player, turn, phase, timeout_pulse, board_clr} !==
                {e_valid, e_cell, e_player, e_turn, e_phase, e_tp, e_clr}) begin
                miscompares++;
                $display("FAIL model t=%0t dut v=%b cell=%0d pl=%b turn=%b ph=%0d to=%b clr=%b | need v=%b cell=%0d pl=%b turn=%b ph=%0d to=%b clr=%b",
                         $time, mv_valid, mv_cell, mv_player, turn, phase, timeout_pulse, board_clr,
                         e_valid, e_cell, e_player, e_turn, e_phase, e_tp, e_clr);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!mv_valid && n < 12) begin @(negedge clk); n++; end
        check(name, mv_valid, 1);
    endtask

    task automatic handshake(input string name);
        mv_ready = 1'b1;
        @(negedge clk);
        mv_ready = 1'b0;
        check(name, mv_valid, 0);
    endtask

    task automatic result(input logic [1:0] code);
        res_valid = 1'b1; res_code = code;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    // Samples while phase == p; returns sample count and whether board_clr was seen.
    task automatic hold_len(input logic [2:0] p, output int n, output bit clr_seen);
        n = 0; clr_seen = 0;
        while (phase == p && n < 30) begin
            n++;
            @(negedge clk);
            if (board_clr) clr_seen = 1;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " outs"}, {mv_valid, mv_cell, mv_player, turn, phase, timeout_pulse}, 0);
        check({name, " clr"}, board_clr, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int  n, pulses, pi, rises;
        bit  clr_seen;
        logic pv;

        cycles(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("clr after reset", board_clr, 0);

        // basic move: key 5 -> cell 4 from P1, visible after edge k+3
        kb_key = 4'd5; kb_ready_n = 1'b0;
        cycles(3);
        check("latency k+2", mv_valid, 0);
        cycles(1);
        check("basic move", {mv_valid, mv_cell, mv_player}, {1'b1, 4'd4, 1'b0});
        kb_ready_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall stable", {mv_valid, mv_cell, mv_player}, {1'b1, 4'd4, 1'b0});
        end
        handshake("basic xfer");
        result(2'd0);
        check("ok turn/phase", {turn, phase}, {1'b1, 3'd1});

        // win by P2 on cell 0
        kb_key = 4'd1; kb_ready_n = 1'b0;
        wait_valid("win valid");
        check("win move", {mv_cell, mv_player}, {4'd0, 1'b1});
        kb_ready_n = 1'b1;
        handshake("win xfer");
        result(2'd1);
        check("win phase", phase, 3);
        hold_len(3'd3, n, clr_seen);
        check("win hold len", (n >= 5 && n <= 8), 1);
        check("win exit", {board_clr, turn, phase}, {1'b1, 1'b0, 3'd0});
        @(negedge clk);
        check("clr one cycle", board_clr, 0);

        // illegal move by P1; a key pressed during the hold is dropped
        kb_key = 4'd3; kb_ready_n = 1'b0;
        wait_valid("illegal valid");
        kb_ready_n = 1'b1;
        handshake("illegal xfer");
        result(2'd3);
        check("illegal phase", phase, 4);
        kb_key = 4'd7; kb_ready_n = 1'b0;
        hold_len(3'd4, n, clr_seen);
        check("illegal exit", {turn, phase}, {1'b0, 3'd0});
        check("illegal no clr", clr_seen, 0);
        kb_ready_n = 1'b1;
        cycles(3);
        check("hold key dropped", mv_valid, 0);

        // bad key 0: error hold without a move
        kb_key = 4'd0; kb_ready_n = 1'b0;
        cycles(4);
        check("bad key phase", {mv_valid, phase}, {1'b0, 3'd4});
        kb_ready_n = 1'b1;
        hold_len(3'd4, n, clr_seen);
        check("bad key exit", {turn, phase, clr_seen}, {1'b0, 3'd0, 1'b0});

        // timeout: one pulse within 12 idle cycles
        pulses = 0; pi = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (timeout_pulse) begin pulses++; pi = i; end
        end
        check("timeout count", pulses, 1);
        check("timeout turn", {turn, phase}, {1'b1, 3'd1});

        // key event lands on the third tick after that timeout: key wins
        if (pulses == 1) begin
            cycles(pi - 4);
            kb_key = 4'd2; kb_ready_n = 1'b0;
            cycles(4);
            check("key beats tick", {mv_valid, mv_cell, mv_player, timeout_pulse, turn},
                  {1'b1, 4'd1, 1'b1, 1'b0, 1'b1});
            kb_ready_n = 1'b1;
        end else begin
            kb_key = 4'd2; kb_ready_n = 1'b0;
            wait_valid("fallback valid");
            kb_ready_n = 1'b1;
        end

        // key during ISSUE is dropped
        cycles(2);
        kb_key = 4'd8; kb_ready_n = 1'b0;
        cycles(2);
        kb_ready_n = 1'b1;
        cycles(4);
        check("issue stable", {mv_valid, mv_cell}, {1'b1, 4'd1});
        handshake("drop xfer");
        cycles(4);
        check("issue key dropped", mv_valid, 0);
        result(2'd0);
        check("back to P1", {turn, phase}, {1'b0, 3'd0});
        cycles(3);
        check("no extra move", mv_valid, 0);

        // key held low for 50 cycles -> one move
        kb_key = 4'd6; kb_ready_n = 1'b0; mv_ready = 1'b1;
        rises = 0; pv = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mv_valid && !pv) rises++;
            res_valid = pv && !mv_valid;
            res_code = 2'd0;
            pv = mv_valid;
        end
        res_valid = 1'b0; mv_ready = 1'b0; kb_ready_n = 1'b1;
        check("held key one move", rises, 1);

        // reset during ISSUE
        cycles(3);
        kb_key = 4'd9; kb_ready_n = 1'b0;
        wait_valid("pre-reset valid");
        kb_ready_n = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset in issue");
        cycles(2);
        check("clr while reset", board_clr, 1);
        reset = 1'b0;

        // reset during HOLD
        cycles(3);
        kb_key = 4'd12; kb_ready_n = 1'b0;
        n = 0;
        while (phase != 3'd4 && n < 12) begin @(negedge clk); n++; end
        check("pre-reset hold", phase, 4);
        kb_ready_n = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset in hold");
        reset = 1'b0;
        cycles(2);
        check("post reset idle", {board_clr, phase, mv_valid}, {1'b0, 3'd0, 1'b0});

        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
